// File: rtl/arb_rr_pry_pkg.sv
// ============================================================================
// Module      : arb_rr_pry_pkg
// Description : Shared types and helpers for the arb_rr_pry round-robin
//               arbiter: FSM state enum, pointer-to-mask and one-hot-to-index.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package arb_rr_pry_pkg;

    localparam int ARB_MAXW    = 64;
    localparam int ARB_MAXIDXW = 6;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Bits strictly above the pointer's set bit: prefix-OR shifted up by one.
    function automatic logic [ARB_MAXW-1:0] ptr2msk(input logic [ARB_MAXW-1:0] ptr);
        logic [ARB_MAXW-1:0] pre;
        pre[0] = ptr[0];
        for (int i = 1; i < ARB_MAXW; i++) begin
            pre[i] = pre[i-1] | ptr[i];
        end
        return pre << 1;
    endfunction

    function automatic logic [ARB_MAXIDXW-1:0] oht2idx(input logic [ARB_MAXW-1:0] oht);
        logic [ARB_MAXIDXW-1:0] idx;
        idx = '0;
        for (int i = 0; i < ARB_MAXW; i++) begin
            if (oht[i]) begin
                idx = idx | ARB_MAXIDXW'(i);
            end
        end
        return idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/arb_rr_pry_if.sv
// ============================================================================
// Module      : arb_rr_pry_if
// Description : Request/grant/handshake bundle of the arb_rr_pry arbiter.
//               The lck signal exists only when ARB_RR_PRY_LOCK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface arb_rr_pry_if #(
    parameter int WIDTH = 8
) ();

    localparam int IDXW = $clog2(WIDTH);

    logic [WIDTH-1:0] req;
    logic [WIDTH-1:0] gnt;
    logic [IDXW-1:0]  idx;
    logic             vld;
    logic             rdy;
`ifdef ARB_RR_PRY_LOCK_EN
    logic             lck;
`endif

    modport master (
        output req,
        output rdy,
`ifdef ARB_RR_PRY_LOCK_EN
        output lck,
`endif
        input  gnt,
        input  idx,
        input  vld
    );

    modport slave (
        input  req,
        input  rdy,
`ifdef ARB_RR_PRY_LOCK_EN
        input  lck,
`endif
        output gnt,
        output idx,
        output vld
    );

endinterface

`default_nettype wire

// File: rtl/pry2oht_tree.sv
// ============================================================================
// Module      : pry2oht_tree
// Description : Priority-to-one-hot encoder built as a SPLIT-ary tree; picks
//               the lowest (DIRECTION "LSB") or highest ("MSB") set request.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pry2oht_tree #(
    parameter int    WIDTH          = 8,
    parameter int    SPLIT          = 2,
    parameter int    IMPLEMENTATION = 0,
    parameter string DIRECTION      = "LSB"
) (
    input  wire logic [WIDTH-1:0] req_i,
    output      logic [WIDTH-1:0] oht_o,
    output      logic             vld_o
);

    if (WIDTH <= SPLIT) begin : g_leaf
        if (IMPLEMENTATION == 1 && DIRECTION == "LSB") begin : g_arith
            // Two's-complement trick isolates the lowest set bit.
            assign oht_o = req_i & (~req_i + WIDTH'(1));
        end else begin : g_scan
            logic [WIDTH-1:0] w_oht;
            always_comb begin
                w_oht = '0;
                for (int i = 0; i < WIDTH; i++) begin
                    if (DIRECTION == "LSB") begin
                        if (req_i[i] && (w_oht == '0)) w_oht[i] = 1'b1;
                    end else begin
                        if (req_i[WIDTH-1-i] && (w_oht == '0)) w_oht[WIDTH-1-i] = 1'b1;
                    end
                end
            end
            assign oht_o = w_oht;
        end
        assign vld_o = |req_i;
    end else begin : g_node
        localparam int SUB = WIDTH / SPLIT;

        logic [WIDTH-1:0] w_sub_oht;
        logic [SPLIT-1:0] w_sub_vld;
        logic [SPLIT-1:0] w_sel;

        for (genvar s = 0; s < SPLIT; s++) begin : g_sub
            pry2oht_tree #(
                .WIDTH          (SUB),
                .SPLIT          (SPLIT),
                .IMPLEMENTATION (IMPLEMENTATION),
                .DIRECTION      (DIRECTION)
            ) u_sub (
                .req_i (req_i[s*SUB +: SUB]),
                .oht_o (w_sub_oht[s*SUB +: SUB]),
                .vld_o (w_sub_vld[s])
            );
            assign oht_o[s*SUB +: SUB] = w_sub_oht[s*SUB +: SUB] & {SUB{w_sel[s]}};
        end

        // The winning subtree is itself chosen by a priority over subtree valids.
        pry2oht_tree #(
            .WIDTH          (SPLIT),
            .SPLIT          (SPLIT),
            .IMPLEMENTATION (IMPLEMENTATION),
            .DIRECTION      (DIRECTION)
        ) u_sel (
            .req_i (w_sub_vld),
            .oht_o (w_sel),
            .vld_o (vld_o)
        );
    end

endmodule

`default_nettype wire

// File: rtl/arb_rr_pry.sv
// ============================================================================
// Module      : arb_rr_pry
// Description : Registered round-robin arbiter with valid/ready grant hold.
//               Optional grant lock enabled by macro ARB_RR_PRY_LOCK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_rr_pry
    import arb_rr_pry_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int SPLIT          = 2,
    parameter int IMPLEMENTATION = 0
) (
    input  wire logic    clk,
    input  wire logic    rst,
    arb_rr_pry_if.slave  bus_if
);

    localparam int               IDXW      = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] C_PTR_RST = {1'b1, {(WIDTH-1){1'b0}}};

    arb_state_t       state_q, state_d;
    logic [WIDTH-1:0] ptr_q, ptr_d;
    logic [WIDTH-1:0] gnt_q, gnt_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             vld_q, vld_d;

    logic [WIDTH-1:0] w_base;
    logic [WIDTH-1:0] w_msk;
    logic [WIDTH-1:0] w_a_oht, w_b_oht, w_arb;
    logic             w_a_vld, w_b_vld;
    logic [IDXW-1:0]  w_arb_idx;
    logic             w_hold;

    // On a transfer the current grant becomes the pointer, so mask from it directly.
    assign w_base    = (state_q == GRANT) ? gnt_q : ptr_q;
    assign w_msk     = WIDTH'(ptr2msk(ARB_MAXW'(w_base)));
    assign w_arb     = w_a_vld ? w_a_oht : w_b_oht;
    assign w_arb_idx = IDXW'(oht2idx(ARB_MAXW'(w_arb)));

`ifdef ARB_RR_PRY_LOCK_EN
    assign w_hold = bus_if.lck && (|(bus_if.req & gnt_q));
`else
    assign w_hold = 1'b0;
`endif

    pry2oht_tree #(
        .WIDTH          (WIDTH),
        .SPLIT          (SPLIT),
        .IMPLEMENTATION (IMPLEMENTATION),
        .DIRECTION      ("LSB")
    ) u_tree_a (
        .req_i (bus_if.req & w_msk),
        .oht_o (w_a_oht),
        .vld_o (w_a_vld)
    );

    pry2oht_tree #(
        .WIDTH          (WIDTH),
        .SPLIT          (SPLIT),
        .IMPLEMENTATION (IMPLEMENTATION),
        .DIRECTION      ("LSB")
    ) u_tree_b (
        .req_i (bus_if.req),
        .oht_o (w_b_oht),
        .vld_o (w_b_vld)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        vld_d   = vld_q;
        case (state_q)
            IDLE: begin
                if (w_b_vld) begin
                    gnt_d   = w_arb;
                    idx_d   = w_arb_idx;
                    vld_d   = 1'b1;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (bus_if.rdy && !w_hold) begin
                    ptr_d = gnt_q;
                    if (w_b_vld) begin
                        gnt_d = w_arb;
                        idx_d = w_arb_idx;
                    end else begin
                        gnt_d   = '0;
                        idx_d   = '0;
                        vld_d   = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                idx_d   = '0;
                vld_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= C_PTR_RST;
            gnt_q   <= '0;
            idx_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            vld_q   <= vld_d;
        end
    end

    assign bus_if.gnt = gnt_q;
    assign bus_if.idx = idx_q;
    assign bus_if.vld = vld_q;

endmodule

`default_nettype wire
